// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default widths, NOP encoding and fetch-queue entry.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle clear.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            push_i,
  input  fq_entry_t       data_i,
  input  logic            pop_i,
  output fq_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Clear wins over push/pop in the same cycle.
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  // Issue credits should make a push into a full queue unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !clear_i) begin
      assert (!full_o) else $error("fetch_queue: push while full");
    end
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order imem fetches and buffers responses
// for IF/ID, honouring branch redirects, flushes and stalls.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_vld,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_rdy,
  input  logic               imem_rsp_vld,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               pc_branch_sel,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic               flush,
  output logic               if_vld,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;  // PC of the oldest non-dropped response
  logic [CntW-1:0]   out_q, out_d;        // requests accepted, response pending
  logic [CntW-1:0]   drop_q, drop_d;      // pending responses that are wrong-path
  logic              live_q;              // first request waits one cycle after reset
  logic [CntW-1:0]   q_count;
  logic              q_empty, q_full_unused;
  logic              credit_ok, req_fire, push, pop, clear;
  logic [ADDR_W-1:0] target_aligned;
  logic              unused_tgt_lsbs;
  fq_entry_t         push_entry, head;

  assign target_aligned  = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lsbs = ^branch_target[1:0];

  // Queued plus in-flight never exceeds depth; pops this cycle are not credited.
  assign credit_ok     = ({1'b0, q_count} + {1'b0, out_q}) < (CntW + 1)'(FQ_DEPTH);
  assign imem_req_vld  = live_q & ~pc_branch_sel & credit_ok;
  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_vld & imem_req_rdy;

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign pop        = ~q_empty & ~stall & ~clear;

  // PC, in-flight bookkeeping and queue control; redirect > flush > normal.
  always_comb begin
    pc_d     = req_fire ? pc_q + ADDR_W'(4) : pc_q;
    out_d    = out_q + CntW'(req_fire) - CntW'(imem_rsp_vld);
    drop_d   = drop_q;
    rsp_pc_d = rsp_pc_q;
    push     = 1'b0;
    clear    = 1'b0;
    if (pc_branch_sel) begin
      pc_d     = target_aligned;
      clear    = 1'b1;
      drop_d   = out_q - CntW'(imem_rsp_vld);
      rsp_pc_d = target_aligned;
    end else if (flush) begin
      clear    = 1'b1;
      drop_d   = out_q - CntW'(imem_rsp_vld);
      rsp_pc_d = pc_q;  // a request firing now is the first valid one
    end else if (imem_rsp_vld) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CntW'(1);
      end else begin
        push     = 1'b1;
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
    end
  end

  // Fetch-control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      live_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      live_q   <= 1'b1;
    end
  end

  fetch_queue #(
    .Depth(FQ_DEPTH)
  ) u_fetch_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(clear),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .head_o (head),
    .count_o(q_count),
    .full_o (q_full_unused),
    .empty_o(q_empty)
  );

  // Head of queue toward IF/ID; NOP and PC 0 while empty.
  always_comb begin
    if_vld      = ~q_empty;
    if_instr    = q_empty ? NOP_INSTR : head.instr;
    if_pc       = q_empty ? '0 : head.pc;
    if_pc_plus4 = if_pc + ADDR_W'(4);
  end

endmodule
